alu_core: RTL and testbench

Parameterised integer ALU for the datapath's execute stage: takes two operands and a 6-bit function code and produces a result with carry and zero flags. Operands and opcode are sampled on the rising clock edge, so results appear one cycle later on registered outputs. It covers add, subtract, bitwise logic and right shifts; the encodings follow the MIPS R-type funct field.

---
 rtl/alu_core.sv | 92 +++++++++
 tb/tb_alu_core.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Registered integer ALU for the execute stage: add, subtract, bitwise logic and right shifts.
// Function codes follow the MIPS R-type funct field; results appear one cycle after sampling.
module alu_core #(
    parameter int unsigned N_BITS = 8,
    parameter int unsigned N_OP   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    input  logic [N_OP-1:0]   op,
    output logic [N_BITS-1:0] rdo,
    output logic              carry,
    output logic              zero
);

    localparam logic [N_OP-1:0] OpAdd = N_OP'(6'b100000);
    localparam logic [N_OP-1:0] OpSub = N_OP'(6'b100010);
    localparam logic [N_OP-1:0] OpAnd = N_OP'(6'b100100);
    localparam logic [N_OP-1:0] OpOr  = N_OP'(6'b100101);
    localparam logic [N_OP-1:0] OpXor = N_OP'(6'b100110);
    localparam logic [N_OP-1:0] OpNor = N_OP'(6'b100111);
    localparam logic [N_OP-1:0] OpSrl = N_OP'(6'b000010);
    localparam logic [N_OP-1:0] OpSra = N_OP'(6'b000011);

    localparam logic [N_BITS:0] ShiftLimit = (N_BITS + 1)'(N_BITS);

    logic [N_BITS:0]   sum_ext;
    logic [N_BITS:0]   diff_ext;
    logic              shift_overflow;
    logic [N_BITS-1:0] srl_res;
    logic [N_BITS-1:0] sra_res;

    logic [N_BITS-1:0] rdo_d, rdo_q;
    logic              carry_d, carry_q;
    logic              zero_d, zero_q;

    // Both operands are zero-extended, so the top bit is carry-out for ADD and borrow for SUB.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    assign shift_overflow = ({1'b0, b} >= ShiftLimit);

    always_comb begin
        srl_res = '0;
        sra_res = {N_BITS{a[N_BITS-1]}};
        if (!shift_overflow) begin
            srl_res = a >> b;
            sra_res = N_BITS'($signed(a) >>> b);
        end
    end

    always_comb begin
        rdo_d   = '0;
        carry_d = 1'b0;
        case (op)
            OpAdd: begin
                rdo_d   = sum_ext[N_BITS-1:0];
                carry_d = sum_ext[N_BITS];
            end
            OpSub: begin
                rdo_d   = diff_ext[N_BITS-1:0];
                carry_d = diff_ext[N_BITS];
            end
            OpAnd:   rdo_d = a & b;
            OpOr:    rdo_d = a | b;
            OpXor:   rdo_d = a ^ b;
            OpNor:   rdo_d = ~(a | b);
            OpSrl:   rdo_d = srl_res;
            OpSra:   rdo_d = sra_res;
            default: rdo_d = '0;
        endcase
        zero_d = (rdo_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdo_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            rdo_q   <= rdo_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign rdo   = rdo_q;
    assign carry = carry_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: the driver queues hand-computed results, the monitor checks
// each one on the cycle after its inputs were sampled.
module tb_alu_core;

    localparam logic [5:0] ADD = 6'b100000;
    localparam logic [5:0] SUB = 6'b100010;
    localparam logic [5:0] AND = 6'b100100;
    localparam logic [5:0] OR  = 6'b100101;
    localparam logic [5:0] XOR = 6'b100110;
    localparam logic [5:0] NOR = 6'b100111;
    localparam logic [5:0] SRL = 6'b000010;
    localparam logic [5:0] SRA = 6'b000011;
    localparam logic [5:0] UND = 6'b111111;

    typedef struct {
        string      name;
        logic [7:0] rdo;
        logic       carry;
        logic       zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [5:0] op = '0;
    logic [7:0] rdo;
    logic       carry;
    logic       zero;

    logic       issued = 1'b0;
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;

    alu_core #(.N_BITS(8), .N_OP(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .op    (op),
        .rdo   (rdo),
        .carry (carry),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic drive(input string name, input logic rst, input logic [7:0] va,
                         input logic [7:0] vb, input logic [5:0] vop, input logic [7:0] e_rdo,
                         input logic e_c, input logic e_z);
        exp_t e;
        @(negedge clk);
        rst_n  = rst;
        a      = va;
        b      = vb;
        op     = vop;
        issued = 1'b1;
        e.name = name;
        e.rdo = e_rdo;
        e.carry = e_c;
        e.zero = e_z;
        sb.push_back(e);
    endtask

    // Monitor: any edge that sampled an issued vector must present the queued result.
    initial begin
        logic cap;
        exp_t e;
        forever begin
            @(posedge clk);
            cap = issued;
            #1;
            if (cap) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL no_expected: rdo=%h carry=%b zero=%b, scoreboard empty",
                             rdo, carry, zero);
                end else begin
                    e = sb.pop_front();
                    if (rdo !== e.rdo || carry !== e.carry || zero !== e.zero) begin
                        errors++;
                        $display("FAIL %s: got rdo=%h carry=%b zero=%b, want rdo=%h carry=%b zero=%b",
                                 e.name, rdo, carry, zero, e.rdo, e.carry, e.zero);
                    end
                end
            end
        end
    end

    initial begin
        drive("reset",        1'b0, 8'hFF, 8'h01, ADD, 8'h00, 1'b0, 1'b1);
        drive("reset_hold",   1'b0, 8'd250, 8'd20, ADD, 8'h00, 1'b0, 1'b1);
        drive("add_carry",    1'b1, 8'd250, 8'd20, ADD, 8'h0E, 1'b1, 1'b0);
        drive("add_wrap0",    1'b1, 8'hFF, 8'h01, ADD, 8'h00, 1'b1, 1'b1);
        drive("add_small",    1'b1, 8'd3, 8'd4, ADD, 8'd7, 1'b0, 1'b0);
        drive("sub_pos",      1'b1, 8'd250, 8'd20, SUB, 8'd230, 1'b0, 1'b0);
        drive("sub_eq",       1'b1, 8'd250, 8'd250, SUB, 8'd0, 1'b0, 1'b1);
        drive("sub_borrow",   1'b1, 8'd20, 8'd250, SUB, 8'd26, 1'b1, 1'b0);
        drive("sub_0_1",      1'b1, 8'd0, 8'd1, SUB, 8'hFF, 1'b1, 1'b0);
        drive("and",          1'b1, 8'b10101010, 8'b11110000, AND, 8'hA0, 1'b0, 1'b0);
        drive("or",           1'b1, 8'b10101010, 8'b11110000, OR,  8'hFA, 1'b0, 1'b0);
        drive("xor",          1'b1, 8'b10101010, 8'b11110000, XOR, 8'h5A, 1'b0, 1'b0);
        drive("nor",          1'b1, 8'b10101010, 8'b11110000, NOR, 8'h05, 1'b0, 1'b0);
        drive("and_zero",     1'b1, 8'h0F, 8'hF0, AND, 8'h00, 1'b0, 1'b1);
        drive("sra_3",        1'b1, 8'b11000000, 8'd3, SRA, 8'hF8, 1'b0, 1'b0);
        drive("srl_3",        1'b1, 8'b11000000, 8'd3, SRL, 8'h18, 1'b0, 1'b0);
        drive("sra_9",        1'b1, 8'b11000000, 8'd9, SRA, 8'hFF, 1'b0, 1'b0);
        drive("srl_9",        1'b1, 8'b11000000, 8'd9, SRL, 8'h00, 1'b0, 1'b1);
        drive("sra_7",        1'b1, 8'h80, 8'd7, SRA, 8'hFF, 1'b0, 1'b0);
        drive("srl_7",        1'b1, 8'h80, 8'd7, SRL, 8'h01, 1'b0, 1'b0);
        drive("sra_8",        1'b1, 8'h80, 8'd8, SRA, 8'hFF, 1'b0, 1'b0);
        drive("srl_8",        1'b1, 8'h80, 8'd8, SRL, 8'h00, 1'b0, 1'b1);
        drive("sra_pos_200",  1'b1, 8'h40, 8'd200, SRA, 8'h00, 1'b0, 1'b1);
        drive("sra_pos_1",    1'b1, 8'h40, 8'd1, SRA, 8'h20, 1'b0, 1'b0);
        drive("srl_0",        1'b1, 8'hA5, 8'd0, SRL, 8'hA5, 1'b0, 1'b0);
        drive("undef",        1'b1, 8'hFF, 8'hFF, UND, 8'h00, 1'b0, 1'b1);
        drive("undef_zero_op",1'b1, 8'h12, 8'h34, 6'b000000, 8'h00, 1'b0, 1'b1);
        drive("add_after",    1'b1, 8'h12, 8'h34, ADD, 8'h46, 1'b0, 1'b0);
        drive("mid_reset",    1'b0, 8'd250, 8'd20, ADD, 8'h00, 1'b0, 1'b1);
        drive("post_reset",   1'b1, 8'd20, 8'd250, SUB, 8'd26, 1'b1, 1'b0);
        @(negedge clk);
        issued = 1'b0;
        a  = 8'h55;
        b  = 8'h0F;
        op = XOR;
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
